// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and helpers.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {StIdle, StEmit, StCalc, StDone} ks_state_t;

  localparam int unsigned AES128_ROUNDS = 10;
  // Round keys 0..AES128_ROUNDS inclusive.
  localparam int unsigned CacheDepth    = AES128_ROUNDS + 1;

  // Rotate a word left by one byte.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_round_fn.sv
// Combinational AES-128 next-round-key function. SubWord and rcon come from
// shared external resources, so this block only does the XOR chain.
module key_round_fn
  import aes_pkg::*;
(
  input  block_t     key_i,
  input  word_t      sbox_word_i,
  input  logic [7:0] rcon_i,
  output block_t     key_o
);

  word_t t, w0, w1, w2, w3;

  // XOR chain: each new word depends on the previous new word.
  always_comb begin
    t     = sbox_word_i ^ {rcon_i, 24'h0};
    w0    = key_i[127:96] ^ t;
    w1    = key_i[95:64]  ^ w0;
    w2    = key_i[63:32]  ^ w1;
    w3    = key_i[31:0]   ^ w2;
    key_o = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-expansion sequencer: loads a key, streams round keys 0..10 over
// valid/ready, driving the external rcon LUT and shared S-box during CALC.
// Optional round-key cache is enabled by defining KEY_SCHED_CACHE_EN.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [127:0] key_i,
  output logic [3:0]   rcon_round_o,
  input  logic [7:0]   rcon_i,
  output logic [31:0]  sbox_word_o,
  input  logic [31:0]  sbox_word_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_data_o,
  output logic [3:0]   rk_round_o,
  output logic         busy_o,
  output logic         done_o,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o,
  output logic         rd_valid_o
);

  if (NUM_ROUNDS != AES128_ROUNDS) begin : gen_bad_rounds
    $error("key_sched_ctrl: NUM_ROUNDS must be 10 (AES-128)");
  end

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  ks_state_t  state_q, state_d;
  block_t     key_q, key_d, key_next;
  logic [3:0] round_q, round_d;
  logic [3:0] rcon_q, rcon_d;
  word_t      sbox_q, sbox_d;
  logic       in_calc, handshake, abort_act, load;

  assign in_calc   = (state_q == StCalc);
  assign abort_act = abort_i && (state_q != StIdle);
  assign handshake = (state_q == StEmit) && rk_ready_i && !abort_i;
  assign load      = (state_q == StIdle) && start_i && !abort_i;

  key_round_fn u_round_fn (
    .key_i       (key_q),
    .sbox_word_i (sbox_word_i),
    .rcon_i      (rcon_i),
    .key_o       (key_next)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= '0;
      sbox_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      sbox_q  <= sbox_d;
    end
  end

  // Next-state logic; abort overrides any transition, including a handshake.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    sbox_d  = sbox_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          key_d   = key_i;
          round_d = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (rk_ready_i) state_d = (round_q == LastRound) ? StDone : StCalc;
      end
      StCalc: begin
        key_d   = key_next;
        round_d = round_q + 4'd1;
        rcon_d  = round_q;
        sbox_d  = rot_word(key_q[31:0]);
        state_d = StEmit;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_act) state_d = StIdle;
  end

  // LUT/S-box request is live in CALC and holds its last value elsewhere.
  always_comb begin
    rcon_round_o = in_calc ? round_q : rcon_q;
    sbox_word_o  = in_calc ? rot_word(key_q[31:0]) : sbox_q;
    rk_valid_o   = (state_q == StEmit);
    rk_data_o    = key_q;
    rk_round_o   = round_q;
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDone);
  end

`ifdef KEY_SCHED_CACHE_EN
  block_t                cache_q [CacheDepth];
  logic [CacheDepth-1:0] valid_q;
  logic                  rd_in_range;

  // Capture each delivered round key; a new run or an abort invalidates all.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (load || abort_act) begin
      valid_q <= '0;
    end else if (handshake) begin
      cache_q[round_q] <= key_q;
      valid_q[round_q] <= 1'b1;
    end
  end

  // Gate with valid so unwritten entries never leak onto rd_key_o.
  always_comb begin
    rd_in_range = (rd_idx_i <= LastRound);
    rd_valid_o  = rd_in_range && valid_q[rd_idx_i];
    rd_key_o    = rd_valid_o ? cache_q[rd_idx_i] : '0;
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx_i;
  assign rd_key_o      = '0;
  assign rd_valid_o    = 1'b0;
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl with a reference rcon LUT and S-box.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_i, start_i, abort_i, rk_ready_i;
  logic [127:0] key_i;
  logic [3:0]   rcon_round_o, rk_round_o, rd_idx_i;
  logic [7:0]   rcon_i;
  logic [31:0]  sbox_word_o, sbox_word_i;
  logic         rk_valid_o, busy_o, done_o, rd_valid_o;
  logic [127:0] rk_data_o, rd_key_o;

  always #5 clk = ~clk;

  key_sched_ctrl u_dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .key_i        (key_i),
    .rcon_round_o (rcon_round_o),
    .rcon_i       (rcon_i),
    .sbox_word_o  (sbox_word_o),
    .sbox_word_i  (sbox_word_i),
    .rk_valid_o   (rk_valid_o),
    .rk_ready_i   (rk_ready_i),
    .rk_data_o    (rk_data_o),
    .rk_round_o   (rk_round_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rd_idx_i     (rd_idx_i),
    .rd_key_o     (rd_key_o),
    .rd_valid_o   (rd_valid_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse (x^254) plus the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, p, e;
    inv = 8'h01; p = x; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, p);
      p = gmul(p, p);
    end
    if (x == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    case (idx)
      4'd0: return 8'h01;  4'd1: return 8'h02;  4'd2: return 8'h04;  4'd3: return 8'h08;
      4'd4: return 8'h10;  4'd5: return 8'h20;  4'd6: return 8'h40;  4'd7: return 8'h80;
      4'd8: return 8'h1b;  4'd9: return 8'h36;  default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    rcon_i      = rcon_lut(rcon_round_o);
    sbox_word_i = {sbox(sbox_word_o[31:24]), sbox(sbox_word_o[23:16]),
                   sbox(sbox_word_o[15:8]), sbox(sbox_word_o[7:0])};
  end

  logic [127:0] fips_rk [11];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] got [11];
  int got_rnd [11];
  int nkeys, ndone, k10_cyc, done_cyc, stab_bad, post_busy, post_valid, timed_out;

  // Pulse start, then observe the stream; ready pattern, optional abort round,
  // optional mid-run start with a different key, optional cache-clear probe.
  task automatic run_stream(input int mode, input int abort_rnd, input bit start_mid,
                            input logic [127:0] alt_key, input bit chk_clear);
    bit hold, rdy;
    logic [127:0] hold_data;
    logic [3:0] hold_rnd;
    int ab_c;
    nkeys = 0; ndone = 0; k10_cyc = -1; done_cyc = -1; stab_bad = 0;
    post_busy = -1; post_valid = -1; timed_out = 1; hold = 0; ab_c = -1;
    hold_data = '0; hold_rnd = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 300; c++) begin
      if (chk_clear && c == 1) check_eq("cache_clr_on_start", rd_valid_o, 1'b0);
      if (ab_c >= 0 && c == ab_c + 1) begin
        post_busy = busy_o; post_valid = rk_valid_o;
      end
      if (done_o) begin ndone++; done_cyc = c; end
      if (hold && (!rk_valid_o || rk_data_o !== hold_data || rk_round_o !== hold_rnd))
        stab_bad++;
      rdy = (mode == 0) || (c % 3 == 0);
      rk_ready_i = rdy;
      if (start_mid && c == 5) begin key_i = alt_key; start_i = 1'b1; end
      if (rk_valid_o && abort_rnd >= 0 && int'(rk_round_o) == abort_rnd && ab_c < 0) begin
        abort_i = 1'b1; ab_c = c;
      end else if (rk_valid_o && rdy && nkeys < 11) begin
        got[nkeys] = rk_data_o; got_rnd[nkeys] = int'(rk_round_o);
        if (rk_round_o == 4'd10) k10_cyc = c;
        nkeys++;
      end
      hold = rk_valid_o && !rdy && !abort_i;
      hold_data = rk_data_o; hold_rnd = rk_round_o;
      if ((ab_c >= 0 && c >= ab_c + 4) || (done_cyc >= 0 && c >= done_cyc + 1)) begin
        timed_out = 0;
        break;
      end
      tick();
      abort_i = 1'b0; start_i = 1'b0;
    end
    abort_i = 1'b0; start_i = 1'b0; rk_ready_i = 1'b1;
    check_eq("stream_timeout", timed_out, 0);
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; rk_ready_i = 1'b1;
    key_i = '0; rd_idx_i = 4'd0;
    tick(); tick();
    check_eq("rst_valid", rk_valid_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_round", rk_round_o, 4'd0);
    check_eq("rst_data", rk_data_o, 128'h0);
    check_eq("rst_rcon", rcon_round_o, 4'd0);
    check_eq("rst_sbox", sbox_word_o, 32'h0);
    check_eq("rst_rd_valid", rd_valid_o, 1'b0);
    check_eq("rst_rd_key", rd_key_o, 128'h0);
    rst_i = 1'b0;
    tick();

    // 1: FIPS-197 key, ready tied high, latency.
    key_i = fips_rk[0];
    run_stream(0, -1, 1'b0, '0, 1'b0);
    check_eq("t1_nkeys", nkeys, 11);
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("t1_rk%0d", i), got[i], fips_rk[i]);
      check_eq($sformatf("t1_rnd%0d", i), got_rnd[i], i);
    end
    check_eq("t1_k10_cycle", k10_cyc, 21);
    check_eq("t1_done_cycle", done_cyc, 22);
    check_eq("t1_ndone", ndone, 1);
    check_eq("t1_busy_after", busy_o, 1'b0);

    // 6: round-key cache readback.
    rd_idx_i = 4'd1; #1;
`ifdef KEY_SCHED_CACHE_EN
    check_eq("t6_rd1_valid", rd_valid_o, 1'b1);
    check_eq("t6_rd1_key", rd_key_o, fips_rk[1]);
    rd_idx_i = 4'd10; #1;
    check_eq("t6_rd10_key", rd_key_o, fips_rk[10]);
    rd_idx_i = 4'd11; #1;
    check_eq("t6_rd11_valid", rd_valid_o, 1'b0);
    rd_idx_i = 4'd1; #1;
`else
    check_eq("t6_nocache_valid", rd_valid_o, 1'b0);
    check_eq("t6_nocache_key", rd_key_o, 128'h0);
`endif

    // 2: same key, 1-in-3 ready; order and hold stability.
    key_i = fips_rk[0];
`ifdef KEY_SCHED_CACHE_EN
    run_stream(1, -1, 1'b0, '0, 1'b1);
`else
    run_stream(1, -1, 1'b0, '0, 1'b0);
`endif
    check_eq("t2_nkeys", nkeys, 11);
    for (int i = 0; i < 11; i++) check_eq($sformatf("t2_rk%0d", i), got[i], fips_rk[i]);
    check_eq("t2_stable", stab_bad, 0);
    check_eq("t2_ndone", ndone, 1);

    // 3: abort coinciding with the round-4 handshake.
    key_i = fips_rk[0];
    run_stream(0, 4, 1'b0, '0, 1'b0);
    check_eq("t3_nkeys", nkeys, 4);
    check_eq("t3_post_busy", post_busy, 0);
    check_eq("t3_post_valid", post_valid, 0);
    check_eq("t3_ndone", ndone, 0);
    check_eq("t3_busy_end", busy_o, 1'b0);

    // 4: start while busy with another key is ignored.
    key_i = fips_rk[0];
    run_stream(0, -1, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0);
    check_eq("t4_nkeys", nkeys, 11);
    for (int i = 0; i < 11; i++) check_eq($sformatf("t4_rk%0d", i), got[i], fips_rk[i]);

    // 5: reset mid-run at round 6, then a fresh key.
    key_i = fips_rk[0];
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 40 && !(rk_valid_o && rk_round_o == 4'd6); i++) tick();
    check_eq("t5_reach_r6", rk_round_o, 4'd6);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("t5_rst_busy", busy_o, 1'b0);
    check_eq("t5_rst_valid", rk_valid_o, 1'b0);
    check_eq("t5_rst_round", rk_round_o, 4'd0);
    check_eq("t5_rst_data", rk_data_o, 128'h0);
    key_i = 128'h000102030405060708090a0b0c0d0e0f;
    run_stream(0, -1, 1'b0, '0, 1'b0);
    check_eq("t5_nkeys", nkeys, 11);
    check_eq("t5_rk0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
    check_eq("t5_rk10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
